// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port dmem between the CPU and an
// external master using burst-limited round-robin arbitration.
//
// Ports:
//   clk, reset            clock, async active-high reset
//   cpu_req/we/adr/wd     CPU request; cpu_rd read data, cpu_stall
//   ext_req/we/adr/wd     external request; ext_rd read data, ext_ack
//   memwrite/dataadr/     muxed dmem port (combinational, zero
//   writedata/readdata    cycle grant latency)
module dmem_arbiter #(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [WIDTH-1:0] cpu_adr,
  input  logic [WIDTH-1:0] cpu_wd,
  output logic [WIDTH-1:0] cpu_rd,
  output logic             cpu_stall,
  input  logic             ext_req,
  input  logic             ext_we,
  input  logic [WIDTH-1:0] ext_adr,
  input  logic [WIDTH-1:0] ext_wd,
  output logic [WIDTH-1:0] ext_rd,
  output logic             ext_ack,
  output logic             memwrite,
  output logic [WIDTH-1:0] dataadr,
  output logic [WIDTH-1:0] writedata,
  input  logic [WIDTH-1:0] readdata
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_BURST);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CPU  = 2'd1,
    EXT  = 2'd2
  } owner_t;

  owner_t        owner, owner_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          cpu_gnt, ext_gnt;
  logic          sat, cpu_wins;

  // cnt saturates at CMAX, so equality means the burst is used up
  assign sat = (cnt == CMAX);

  // under contention: idle owner favours CPU, otherwise the
  // current owner keeps the port until its burst is spent
  assign cpu_wins = (owner == NONE)
                  | ((owner == CPU) & ~sat)
                  | ((owner == EXT) &  sat);

  always_comb begin
    cpu_gnt  = 1'b0;
    ext_gnt  = 1'b0;
    owner_nx = NONE;
    cnt_nx   = '0;
    if (!reset) begin
      unique case ({cpu_req, ext_req})
        2'b10: cpu_gnt = 1'b1;
        2'b01: ext_gnt = 1'b1;
        2'b11: begin
          cpu_gnt = cpu_wins;
          ext_gnt = ~cpu_wins;
        end
        default: ;
      endcase
    end
    if (cpu_gnt) begin
      owner_nx = CPU;
      if (owner != CPU) cnt_nx = ONE;
      else if (sat)     cnt_nx = cnt;
      else              cnt_nx = cnt + ONE;
    end else if (ext_gnt) begin
      owner_nx = EXT;
      if (owner != EXT) cnt_nx = ONE;
      else if (sat)     cnt_nx = cnt;
      else              cnt_nx = cnt + ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner <= NONE;
      cnt   <= '0;
    end else begin
      owner <= owner_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    memwrite  = 1'b0;
    dataadr   = '0;
    writedata = '0;
    cpu_rd    = '0;
    ext_rd    = '0;
    unique case (1'b1)
      cpu_gnt: begin
        memwrite  = cpu_we;
        dataadr   = cpu_adr;
        writedata = cpu_wd;
        cpu_rd    = readdata;
      end
      ext_gnt: begin
        memwrite  = ext_we;
        dataadr   = ext_adr;
        writedata = ext_wd;
        ext_rd    = readdata;
      end
      default: ;
    endcase
  end

  // grants are already forced low in reset; gate stall the same way
  assign cpu_stall = cpu_req & ~cpu_gnt & ~reset;
  assign ext_ack   = ext_gnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors for dmem_arbiter with a
// scoreboard queue checked by an independent negedge monitor.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_adr, cpu_wd, cpu_rd;
  logic        cpu_stall;
  logic        ext_req, ext_we;
  logic [31:0] ext_adr, ext_wd, ext_rd;
  logic        ext_ack;
  logic        memwrite;
  logic [31:0] dataadr, writedata, readdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.WIDTH(32), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_adr(cpu_adr), .cpu_wd(cpu_wd),
    .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we),
    .ext_adr(ext_adr), .ext_wd(ext_wd),
    .ext_rd(ext_rd), .ext_ack(ext_ack),
    .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .readdata(readdata)
  );

  // small dmem: word i starts as 0x1000_0000 | i
  logic [31:0] mem [64];
  logic        init_done;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 64; i++)
        mem[i] <= 32'h1000_0000 | 32'(i);
    end else if (memwrite) begin
      mem[dataadr[7:2]] <= writedata;
    end
  end

  assign readdata = mem[dataadr[7:2]];

  typedef struct {
    int          g;
    logic        chk;
    logic        mw;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] crd;
    logic [31:0] erd;
    logic        stall;
    logic        ack;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc_no = 0;

  // g: expected grant (0 none, 1 cpu, 2 ext); rd checked when chk
  task automatic cyc(
    input bit rst,
    input bit cr, input bit cw,
    input logic [31:0] ca, input logic [31:0] cwd,
    input bit er, input bit ew,
    input logic [31:0] ea, input logic [31:0] ewd,
    input int g, input bit chk, input logic [31:0] rd
  );
    exp_t e;
    @(posedge clk);
    #1;
    reset   = rst;
    cpu_req = cr;  cpu_we = cw;
    cpu_adr = ca;  cpu_wd = cwd;
    ext_req = er;  ext_we = ew;
    ext_adr = ea;  ext_wd = ewd;
    e.g     = g;
    e.chk   = chk;
    e.mw    = (g == 1) ? cw  : (g == 2) ? ew  : 1'b0;
    e.adr   = (g == 1) ? ca  : (g == 2) ? ea  : 32'h0;
    e.wd    = (g == 1) ? cwd : (g == 2) ? ewd : 32'h0;
    e.crd   = (g == 1) ? rd  : 32'h0;
    e.erd   = (g == 2) ? rd  : 32'h0;
    e.stall = !rst && cr && (g != 1);
    e.ack   = (g == 2);
    q.push_back(e);
  endtask

  // monitor: one expectation per driven cycle, checked mid-cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      bit   bad;
      e = q.pop_front();
      cyc_no++;
      bad = (memwrite  !== e.mw)
         || (dataadr   !== e.adr)
         || (writedata !== e.wd)
         || (cpu_stall !== e.stall)
         || (ext_ack   !== e.ack);
      if ((e.g != 1 || e.chk) && cpu_rd !== e.crd) bad = 1;
      if ((e.g != 2 || e.chk) && ext_rd !== e.erd) bad = 1;
      n_cmp++;
      if (bad) begin
        n_bad++;
        $display("FAIL cycle%0d: got mw=%0b adr=%h wd=%h crd=%h erd=%h stall=%0b ack=%0b want mw=%0b adr=%h wd=%h crd=%h erd=%h stall=%0b ack=%0b",
          cyc_no, memwrite, dataadr, writedata, cpu_rd, ext_rd,
          cpu_stall, ext_ack, e.mw, e.adr, e.wd, e.crd, e.erd,
          e.stall, e.ack);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "timeout");
  end

  localparam logic [31:0] Z = 32'h0;

  initial begin
    init_done = 1'b0;
    reset   = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_adr = Z; cpu_wd = Z;
    ext_req = 0; ext_we = 0; ext_adr = Z; ext_wd = Z;
    @(posedge clk);
    #1 init_done = 1'b1;

    // reset with both requesting writes: everything low
    cyc(1, 1,1,32'h54,32'd7, 1,1,32'h60,32'd5, 0,0,Z);
    cyc(1, 1,1,32'h54,32'd7, 1,1,32'h60,32'd5, 0,0,Z);
    // first cycle out of reset goes to CPU
    cyc(0, 1,1,32'h54,32'd7, 1,1,32'h60,32'd5, 1,0,Z);
    cyc(0, 0,0,Z,Z, 0,0,Z,Z, 0,0,Z);

    // CPU only: write then read back
    cyc(0, 1,1,32'h54,32'd7, 0,0,Z,Z, 1,0,Z);
    cyc(0, 1,0,32'h54,Z,     0,0,Z,Z, 1,1,32'd7);

    // external only: write then read back
    cyc(0, 0,0,Z,Z, 1,1,32'h60,32'hDEADBEEF, 2,0,Z);
    cyc(0, 0,0,Z,Z, 1,0,32'h60,Z, 2,1,32'hDEADBEEF);
    cyc(0, 0,0,Z,Z, 0,0,Z,Z, 0,0,Z);

    // contention from idle: CPUx4 EXTx4 CPUx4
    for (int i = 0; i < 12; i++) begin
      if (i >= 4 && i < 8)
        cyc(0, 1,0,32'h10,Z, 1,0,32'h20,Z, 2,1,32'h1000_0008);
      else
        cyc(0, 1,0,32'h10,Z, 1,0,32'h20,Z, 1,1,32'h1000_0004);
    end
    cyc(0, 0,0,Z,Z, 0,0,Z,Z, 0,0,Z);

    // lone EXT saturates; CPU joining wins at once
    for (int i = 0; i < 10; i++)
      cyc(0, 0,0,Z,Z, 1,0,32'h24,Z, 2,1,32'h1000_0009);
    for (int i = 0; i < 4; i++)
      cyc(0, 1,0,32'h10,Z, 1,0,32'h24,Z, 1,1,32'h1000_0004);
    cyc(0, 1,0,32'h10,Z, 1,0,32'h24,Z, 2,1,32'h1000_0009);
    cyc(0, 0,0,Z,Z, 0,0,Z,Z, 0,0,Z);

    // owner drops req for a cycle: other side takes the burst
    cyc(0, 1,0,32'h10,Z, 1,0,32'h24,Z, 1,1,32'h1000_0004);
    cyc(0, 0,0,Z,Z,      1,0,32'h24,Z, 2,1,32'h1000_0009);
    cyc(0, 1,0,32'h10,Z, 1,0,32'h24,Z, 2,1,32'h1000_0009);
    cyc(0, 0,0,Z,Z, 0,0,Z,Z, 0,0,Z);

    // reset during EXT burst: write to 0x80 must not land
    cyc(0, 0,0,Z,Z, 1,1,32'h7C,32'hAAAA0001, 2,0,Z);
    cyc(1, 0,0,Z,Z, 1,1,32'h80,32'hBBBB0002, 0,0,Z);
    cyc(0, 0,0,Z,Z, 1,0,32'h80,Z, 2,1,32'h1000_0020);
    cyc(0, 0,0,Z,Z, 1,0,32'h7C,Z, 2,1,32'hAAAA0001);
    cyc(0, 0,0,Z,Z, 0,0,Z,Z, 0,0,Z);

    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data memory (dmem) between the MIPS CPU load/store path and an external master (program loader / DMA / debug port). It sits between `cpu` and `dmem` inside `computer`. Each cycle it grants at most one requester using burst-limited round-robin, muxes the granted request onto the dmem port, returns read data, and stalls the CPU while the external master owns memory.

## Interface
Parameters:
- `WIDTH`, 32: address and data width.
- `MAX_BURST`, 4: maximum consecutive grants to one requester while the other is requesting (≥1).

Ports:
- `clk`  in  1: the single clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `cpu_req`  in  1: CPU memory access request, for loads and stores.
- `cpu_we`  in  1: CPU write enable, qualified by `cpu_req`.
- `cpu_adr`  in  WIDTH: CPU byte address.
- `cpu_wd`  in  WIDTH: CPU write data.
- `cpu_rd`  out  WIDTH: read data to CPU.
- `cpu_stall`  out  1: CPU request pending but not granted this cycle.
- `ext_req`  in  1: external master request.
- `ext_we`  in  1: external write enable.
- `ext_adr`  in  WIDTH: external byte address.
- `ext_wd`  in  WIDTH: external write data.
- `ext_rd`  out  WIDTH: read data to external master.
- `ext_ack`  out  1: external request granted this cycle.
- `memwrite`  out  1: dmem write enable.
- `dataadr`  out  WIDTH: dmem address.
- `writedata`  out  WIDTH: dmem write data.
- `readdata`  in  WIDTH: dmem combinational read data.

## Operation
- State registers:
  - `owner` ∈ {NONE, CPU, EXT}: the requester granted last cycle.
  - `cnt` (0..MAX_BURST, saturating): consecutive grants to `owner`.
- Grant decision (combinational, from requests and state):
  - No request: no grant.
  - One request: that requester is granted.
  - Both requesting, `owner`=NONE: CPU wins.
  - Both requesting, `owner`=X and `cnt`<MAX_BURST: X keeps the grant.
  - Both requesting, `owner`=X and `cnt`≥MAX_BURST: the other requester wins.
- Memory mux:
  - Granted G: `dataadr`=G_adr, `writedata`=G_wd, `memwrite`=G_we.
  - No grant: all three are 0.
- Read return:
  - `cpu_rd`=`readdata` when CPU granted, else 0.
  - `ext_rd`=`readdata` when EXT granted, else 0.
- Status outputs: `cpu_stall` = `cpu_req` & ~cpu_gnt; `ext_ack` = ext_gnt.
- State update at the rising edge:
  - Granted G = `owner`: `cnt` <= min(`cnt`+1, MAX_BURST).
  - Granted G ≠ `owner`: `owner` <= G, `cnt` <= 1.
  - No grant: `owner` <= NONE, `cnt` <= 0.
- `we` is ignored when the matching `req` is low. Address is passed through unmodified; dmem does its own word indexing.

## Timing
- Reset value while `reset` is high (asynchronous, overrides all):
  - `owner`=NONE, `cnt`=0.
  - All outputs 0: `memwrite`, `dataadr`, `writedata`, `cpu_rd`, `ext_rd`, `cpu_stall`, `ext_ack`, regardless of requests.
- The first cycle after deassertion behaves as `owner`=NONE.
- Zero-cycle grant latency:
  - Read data is valid in the same cycle as grant, because dmem reads combinationally.
  - A granted write commits at the rising edge that ends the grant cycle.
- Requesters must hold `req`/`we`/`adr`/`wd` stable until granted.
  - CPU: holds while `cpu_stall`=1, since the CPU freezes PC/pipeline on stall.
  - EXT: holds until `ext_ack`=1.
- Fairness: with both requesting continuously, grants alternate in runs of exactly MAX_BURST cycles. The first run belongs to CPU if `owner` was NONE.
  - Max wait for either requester is MAX_BURST cycles.
- Request drops: if the owner drops `req` for one cycle while the other requests, the other is granted and the burst restarts.
- Reset asserted mid-burst: the grant is cut immediately and no write occurs on the next edge, since `memwrite` is 0 while reset is high.

## Test plan
- Reset: assert `reset` with both `req`=1, `cpu_we`=1 -> `memwrite`=0, `cpu_stall`=0, `ext_ack`=0, `dataadr`=0; after release, the first cycle grants CPU.
- CPU only: `cpu_req`=1, `cpu_we`=1, `cpu_adr`=0x54, `cpu_wd`=7 for 1 cycle -> `memwrite`=1, `dataadr`=0x54, `writedata`=7, `cpu_stall`=0; a following read of 0x54 -> `cpu_rd`=7.
- External only: EXT writes 0xDEADBEEF to 0x60, then reads it -> `ext_ack`=1 both cycles, `ext_rd`=0xDEADBEEF on the read; `cpu_rd`=0.
- Contention with MAX_BURST=4 and both `req` held 12 cycles from idle -> grant sequence CPU×4, EXT×4, CPU×4; `cpu_stall`=1 exactly in cycles 5-8.
- Lone requester: EXT alone for 10 cycles, then CPU joins -> `cnt` saturates at 4, so CPU is granted the very next cycle; EXT then waits ≤4 cycles.
- Reset mid-burst: EXT writing 0x80 in cycle 2 of its burst, `reset` pulsed -> no write to 0x80 at that edge; dmem[0x80] is unchanged.
